fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
- Shares one streaming FFT core (N-point, contiguous in_valid burst in, contiguous out_valid burst out) between two frame sources.
- Round-robin arbitration; each grant is exactly N contiguous input cycles; zero-pads any source stall so the core never sees a gap.
- Tags each frame and returns the core's output burst with the owning source id.
- Sits between source buffers and the FFT core.

Parameters:
N, 2048, points per frame (power of 2, >=4)
DW, 16, input sample width per component (signed)
OW, 26, FFT output width per component (signed)
MAX_OUT, 2, frames allowed inside the core (granted, last output beat not yet returned); tag FIFO depth

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s0_req  in  1  source 0 holds a frame ready
s0_valid  in  1  source 0 sample valid
s0_re, s0_im  in  DW each  source 0 sample
s0_grant  out  1  source 0 owns the core input this cycle
s1_req, s1_valid, s1_re, s1_im, s1_grant  as s0, for source 1
fft_in_valid  out  1  to core in_valid
fft_d_re, fft_d_im  out  DW each  to core D_re/D_im
fft_o_re, fft_o_im  in  OW each  from core O_re/O_im
fft_out_valid  in  1  from core out_valid
m_valid  out  1  result beat valid
m_re, m_im  out  OW each  result beat
m_id  out  1  owning source of the beat
m_last  out  1  final (N-th) beat of a frame
pad_err  out  1  one-cycle pulse: granted source had s_valid low
tag_err  out  1  one-cycle pulse: fft_out_valid with empty tag FIFO

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counters 0, tag FIFO empty, RR pointer favours s0. Mid-frame reset aborts the frame; no partial completion afterwards.
- FSM states IDLE, STREAM.
- IDLE:
  - If tag count < MAX_OUT and any req: pick winner (both requesting -> the one not granted last; first ever -> s0).
  - Next cycle: STREAM, winner's grant=1, push winner id to tag FIFO.
  - Tag FIFO full: stay IDLE, no grant, reqs ignored.
- STREAM:
  - Grant held high exactly N consecutive cycles; in_cnt counts 0..N-1; then IDLE with grant=0 (at least one idle cycle between frames).
  - Each grant cycle consumes one beat.
  - s_valid=1: beat = source data.
  - s_valid=0: beat = 0/0 and pad_err pulses.
  - req is not sampled during STREAM.
- Input datapath registered:
  - fft_in_valid, fft_d_re, fft_d_im = grant and selected/padded data delayed one cycle.
  - fft_in_valid is therefore exactly N contiguous cycles per frame.
  - fft_d_* = 0 when fft_in_valid=0.
- Output path, registered, 1-cycle latency:
  - On fft_out_valid: m_valid=1, m_re/m_im = core data, m_id = tag FIFO head, out_cnt++.
  - At out_cnt=N-1: m_last=1, pop tag, out_cnt=0.
  - Empty FIFO on fft_out_valid: tag_err pulses, beat forwarded with m_id=0, no pop, out_cnt still advances.
  - When m_valid=0: m_* = 0.
- Simultaneous push (new grant) and pop (last beat) same cycle: count unchanged. A pop in cycle t frees a slot for arbitration in cycle t+1.
- No backpressure on m_*; sink always accepts.
- Counters: clog2(N) bits, wrap at N-1.

Test Plan:
- N=8, only s0_req, s0_valid=1, samples re=1..8, im=0: s0_grant high 8 cycles starting 1 cycle after req; fft_in_valid high 8 cycles, one cycle later, data 1..8; no pad_err.
- Both req from reset, N=8: s0 granted first, s1 next (after 1 idle cycle), then s0; core returns two 8-beat bursts -> first burst m_id=0, second m_id=1, m_last on beats 8 and 16.
- MAX_OUT=2, core model delays out_valid 40 cycles, both req held: two grants issued, third withheld until the first frame's m_last; re-grant exactly 1 cycle after the pop.
- s1 granted, s1_valid low on beats 3 and 4 (N=8): fft_d 0/0 on those beats, pad_err pulses twice, fft_in_valid stays contiguous 8 cycles.
- fft_out_valid driven with empty FIFO: tag_err=1 one cycle, m_valid=1, m_id=0.
- Assert rst_n=0 mid-STREAM at beat 5: all outputs 0 immediately; after release, FSM IDLE, FIFO empty, next frame gets a full N-beat grant.
- Default N=2048, DW=16, OW=26 smoke run against real FFT core: 2048-beat result, m_last on beat 2048.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - round-robin sharing of one streaming FFT core between two frame sources
// Pads source stalls with zeros and tags each returned burst with its owning source id.
module fft_frame_scheduler #(
  parameter int N       = 2048,
  parameter int DW      = 16,
  parameter int OW      = 26,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s0_req,
  input  logic                 s0_valid,
  input  logic signed [DW-1:0] s0_re,
  input  logic signed [DW-1:0] s0_im,
  output logic                 s0_grant,
  input  logic                 s1_req,
  input  logic                 s1_valid,
  input  logic signed [DW-1:0] s1_re,
  input  logic signed [DW-1:0] s1_im,
  output logic                 s1_grant,
  output logic                 fft_in_valid,
  output logic signed [DW-1:0] fft_d_re,
  output logic signed [DW-1:0] fft_d_im,
  input  logic signed [OW-1:0] fft_o_re,
  input  logic signed [OW-1:0] fft_o_im,
  input  logic                 fft_out_valid,
  output logic                 m_valid,
  output logic signed [OW-1:0] m_re,
  output logic signed [OW-1:0] m_im,
  output logic                 m_id,
  output logic                 m_last,
  output logic                 pad_err,
  output logic                 tag_err
);

  localparam int CW = $clog2(N);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int TW = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        in_cnt, out_cnt;
  logic                 owner, rr_last;
  logic [MAX_OUT-1:0]   tag_mem;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [TW-1:0]        tag_cnt;
  logic                 start, winner;
  logic                 grant_any, sel_valid;
  logic signed [DW-1:0] sel_re, sel_im;
  logic                 tag_empty, tag_pop, out_at_end;

  assign grant_any  = (state == STREAM);
  assign s0_grant   = grant_any && !owner;
  assign s1_grant   = grant_any && owner;
  assign sel_valid  = owner ? s1_valid : s0_valid;
  assign sel_re     = owner ? s1_re : s0_re;
  assign sel_im     = owner ? s1_im : s0_im;
  assign tag_empty  = (tag_cnt == '0);
  assign out_at_end = (out_cnt == CW'(N - 1));
  assign tag_pop    = fft_out_valid && out_at_end && !tag_empty;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    winner   = 1'b0;
    case (state)
      IDLE: begin
        // a full tag FIFO blocks arbitration entirely; requests are simply not seen
        if ((tag_cnt < TW'(MAX_OUT)) && (s0_req || s1_req)) begin
          start    = 1'b1;
          winner   = (s0_req && s1_req) ? ~rr_last : ~s0_req;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        if (in_cnt == CW'(N - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      in_cnt  <= '0;
      owner   <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_any) in_cnt <= in_cnt + CW'(1);
      if (start) begin
        owner   <= winner;
        rr_last <= winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_in_valid <= 1'b0;
      fft_d_re     <= '0;
      fft_d_im     <= '0;
      pad_err      <= 1'b0;
    end else begin
      fft_in_valid <= grant_any;
      fft_d_re     <= (grant_any && sel_valid) ? sel_re : '0;
      fft_d_im     <= (grant_any && sel_valid) ? sel_im : '0;
      pad_err      <= grant_any && !sel_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (start) begin
        tag_mem[wr_ptr] <= winner;
        wr_ptr <= (wr_ptr == PW'(MAX_OUT - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (tag_pop) rd_ptr <= (rd_ptr == PW'(MAX_OUT - 1)) ? '0 : rd_ptr + PW'(1);
      case ({start, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + TW'(1);
        2'b01:   tag_cnt <= tag_cnt - TW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // out_cnt advances even without a tag so a stray burst keeps its own frame alignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_id    <= 1'b0;
      m_last  <= 1'b0;
      tag_err <= 1'b0;
      out_cnt <= '0;
    end else begin
      m_valid <= fft_out_valid;
      m_re    <= fft_out_valid ? fft_o_re : '0;
      m_im    <= fft_out_valid ? fft_o_im : '0;
      m_id    <= fft_out_valid && !tag_empty && tag_mem[rd_ptr];
      m_last  <= fft_out_valid && out_at_end;
      tag_err <= fft_out_valid && tag_empty;
      if (fft_out_valid) out_cnt <= out_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - scoreboard bench for fft_frame_scheduler with a delay-line core model
module tb_fft_frame_scheduler;
  localparam int N = 8, DW = 16, OW = 26, MAX_OUT = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s0_req = 0, s0_valid = 0, s1_req = 0, s1_valid = 0;
  logic signed [DW-1:0] s0_re = 0, s0_im = 0, s1_re = 0, s1_im = 0;
  logic s0_grant, s1_grant, fft_in_valid;
  logic signed [DW-1:0] fft_d_re, fft_d_im;
  logic signed [OW-1:0] fft_o_re = 0, fft_o_im = 0;
  logic fft_out_valid = 0;
  logic m_valid, m_id, m_last, pad_err, tag_err;
  logic signed [OW-1:0] m_re, m_im;

  fft_frame_scheduler #(.N(N), .DW(DW), .OW(OW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_req(s0_req), .s0_valid(s0_valid), .s0_re(s0_re), .s0_im(s0_im), .s0_grant(s0_grant),
    .s1_req(s1_req), .s1_valid(s1_valid), .s1_re(s1_re), .s1_im(s1_im), .s1_grant(s1_grant),
    .fft_in_valid(fft_in_valid), .fft_d_re(fft_d_re), .fft_d_im(fft_d_im),
    .fft_o_re(fft_o_re), .fft_o_im(fft_o_im), .fft_out_valid(fft_out_valid),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_id(m_id), .m_last(m_last),
    .pad_err(pad_err), .tag_err(tag_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int t; logic signed [DW-1:0] re, im; } core_t;
  typedef struct { logic signed [DW-1:0] re, im; logic pad; } in_t;
  typedef struct { logic signed [OW-1:0] re, im; logic id, last, terr; } out_t;
  typedef struct { int t; int id; } grant_t;

  core_t  core_q[$];
  in_t    in_q[$];
  out_t   out_q[$];
  grant_t grant_log[$];
  int     mlast_q[$];

  int cyc = 0, n_cmp = 0, n_fail = 0;
  int lat = 3, pad_cnt = 0, beats = 0, in_rise = 0, run_in = 0, run_g = 0;
  int idx[2], fr[2];
  logic [N-1:0] gap[2];
  logic force_ov = 0;
  logic signed [OW-1:0] force_re = 0, force_im = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // source model: reacts to its grant, pushes the expected core input and result beats
  task automatic drive_src(input int s);
    logic g, v;
    logic signed [DW-1:0] r, i;
    logic signed [OW-1:0] ore, oim;
    in_t  ie;
    out_t oe;
    g = (s == 0) ? s0_grant : s1_grant;
    v = 1'b0; r = '0; i = '0;
    if (g) begin
      v = !gap[s][idx[s]];
      r = (s == 0) ? DW'(16 * fr[s] + idx[s] + 1) : DW'(-(16 * fr[s] + idx[s] + 1));
      i = (s == 0) ? DW'(3 * fr[s]) : DW'(100 + idx[s]);
      ie.re = v ? r : '0; ie.im = v ? i : '0; ie.pad = !v;
      in_q.push_back(ie);
      ore = ie.re; oim = ie.im;
      oe.re = ore * 2; oe.im = oim + 5; oe.id = (s == 1); oe.last = (idx[s] == N - 1); oe.terr = 1'b0;
      out_q.push_back(oe);
      idx[s]++;
      if (idx[s] == N) begin idx[s] = 0; fr[s]++; end
    end
    if (s == 0) begin s0_valid = v; s0_re = r; s0_im = i; end
    else        begin s1_valid = v; s1_re = r; s1_im = i; end
  endtask

  initial forever begin
    @(negedge clk);
    drive_src(0);
    drive_src(1);
  end

  // core model: fixed-latency per-beat delay line, re*2 and im+5
  initial forever begin
    core_t c;
    logic signed [OW-1:0] a, b;
    @(negedge clk);
    if (fft_in_valid && rst_n) core_q.push_back('{cyc, fft_d_re, fft_d_im});
    fft_out_valid = 1'b0; fft_o_re = '0; fft_o_im = '0;
    if (force_ov) begin
      fft_out_valid = 1'b1; fft_o_re = force_re; fft_o_im = force_im; force_ov = 1'b0;
    end else if (core_q.size() > 0 && core_q[0].t + lat <= cyc) begin
      c = core_q.pop_front();
      a = c.re; b = c.im;
      fft_out_valid = 1'b1; fft_o_re = a * 2; fft_o_im = b + 5;
    end
  end

  initial forever begin
    in_t  ie;
    out_t oe;
    logic g;
    @(negedge clk);
    g = s0_grant || s1_grant;
    if (!rst_n) begin
      run_in = 0; run_g = 0;
    end else begin
      if (fft_in_valid) begin
        if (in_q.size() == 0) check("in_unexpected", 1, 0);
        else begin
          ie = in_q.pop_front();
          check("fft_d_re", fft_d_re, ie.re);
          check("fft_d_im", fft_d_im, ie.im);
          check("pad_err", pad_err, ie.pad);
        end
        if (run_in == 0) in_rise = cyc;
        run_in++;
      end else if (run_in > 0) begin
        check("in_run_len", run_in, N);
        run_in = 0;
      end
      if (pad_err) pad_cnt++;
      if (g && run_g == 0) grant_log.push_back('{cyc, int'(s1_grant)});
      if (g) run_g++;
      else if (run_g > 0) begin
        check("grant_len", run_g, N);
        run_g = 0;
      end
      if (m_valid) begin
        beats++;
        if (m_last) mlast_q.push_back(cyc);
        if (out_q.size() == 0) check("out_unexpected", 1, 0);
        else begin
          oe = out_q.pop_front();
          check("m_re", m_re, oe.re);
          check("m_im", m_im, oe.im);
          check("m_id", m_id, oe.id);
          check("m_last", m_last, oe.last);
          check("tag_err", tag_err, oe.terr);
        end
      end
    end
  end

  function automatic logic any_out();
    return |{s0_grant, s1_grant, fft_in_valid, fft_d_re, fft_d_im, m_valid, m_re, m_im,
             m_id, m_last, pad_err, tag_err};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    core_q.delete(); in_q.delete(); out_q.delete(); grant_log.delete(); mlast_q.delete();
    idx[0] = 0; idx[1] = 0; pad_cnt = 0; beats = 0;
    #1 check("reset_outputs_zero", any_out(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grants(input string name, input int n);
    for (int i = 0; i < 300 && grant_log.size() < n; i++) @(posedge clk);
    #1 check(name, grant_log.size() >= n, 1);
  endtask

  task automatic wait_drain(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      done = in_q.size() == 0 && out_q.size() == 0 && core_q.size() == 0 &&
             !s0_grant && !s1_grant && !fft_in_valid && !m_valid;
    end
    check(name, done, 1);
  endtask

  initial begin
    int t0, b0, g;
    fr[0] = 0; fr[1] = 0; gap[0] = '0; gap[1] = '0;
    do_reset();

    // single source, clean frame
    lat = 3; @(posedge clk); #1; t0 = cyc; s0_req = 1;
    wait_grants("t1_grant_seen", 1); s0_req = 0;
    wait_drain("t1_drain");
    if (grant_log.size() >= 1) begin
      check("t1_grant_rise", grant_log[0].t, t0 + 1);
      check("t1_grant_id", grant_log[0].id, 0);
    end
    check("t1_in_rise", in_rise, t0 + 2);
    check("t1_pad_cnt", pad_cnt, 0);
    check("t1_beats", beats, N);
    check("t1_mlast_cnt", mlast_q.size(), 1);
    if (mlast_q.size() >= 1) check("t1_mlast_cyc", mlast_q[0], t0 + 13);

    // both requesting from reset: s0, s1, s0
    do_reset(); lat = 3; t0 = cyc; s0_req = 1; s1_req = 1;
    wait_grants("t2_grants_seen", 3); s0_req = 0; s1_req = 0;
    wait_drain("t2_drain");
    if (grant_log.size() >= 3) begin
      check("t2_id0", grant_log[0].id, 0);
      check("t2_id1", grant_log[1].id, 1);
      check("t2_id2", grant_log[2].id, 0);
      check("t2_rise1", grant_log[1].t, t0 + 10);
      check("t2_rise2", grant_log[2].t, t0 + 19);
    end
    check("t2_beats", beats, 3 * N);
    check("t2_mlast_cnt", mlast_q.size(), 3);

    // slow core: third grant held until the first frame's last beat pops a tag
    do_reset(); lat = 40; t0 = cyc; s0_req = 1; s1_req = 1;
    wait_grants("t3_grants_seen", 3); s0_req = 0; s1_req = 0;
    wait_drain("t3_drain");
    if (grant_log.size() >= 3 && mlast_q.size() >= 1) begin
      check("t3_rise1", grant_log[1].t, t0 + 10);
      check("t3_mlast0", mlast_q[0], t0 + 50);
      check("t3_regrant_after_pop", grant_log[2].t, mlast_q[0] + 1);
      check("t3_id2", grant_log[2].id, 0);
    end
    check("t3_beats", beats, 3 * N);

    // s1 stalls on beats 3 and 4
    do_reset(); lat = 3; gap[1] = 8'b0000_1100; s1_req = 1;
    wait_grants("t4_grant_seen", 1); s1_req = 0;
    wait_drain("t4_drain"); gap[1] = '0;
    if (grant_log.size() >= 1) check("t4_grant_id", grant_log[0].id, 1);
    check("t4_pad_cnt", pad_cnt, 2);
    check("t4_beats", beats, N);

    // core output with no frame outstanding
    b0 = beats;
    out_q.push_back('{OW'(123), OW'(-7), 1'b0, 1'b0, 1'b1});
    force_re = 123; force_im = -7; force_ov = 1;
    repeat (4) @(posedge clk); #1;
    check("t5_beats", beats - b0, 1);
    check("t5_out_q_empty", out_q.size(), 0);

    // reset mid-frame after beat 5, then a fresh s1 frame must be tagged 1
    do_reset(); lat = 3; s0_req = 1;
    wait_grants("t6_grant_seen", 1); s0_req = 0;
    g = (grant_log.size() >= 1) ? grant_log[0].t : cyc;
    for (int i = 0; i < 20 && cyc < g + 5; i++) @(posedge clk);
    #1 check("t6_in_stream", fft_in_valid, 1);
    do_reset(); t0 = cyc; s1_req = 1;
    wait_grants("t6_regrant_seen", 1); s1_req = 0;
    wait_drain("t6_drain");
    if (grant_log.size() >= 1) begin
      check("t6_rise", grant_log[0].t, t0 + 1);
      check("t6_id", grant_log[0].id, 1);
    end
    check("t6_beats", beats, N);
    check("t6_mlast_cnt", mlast_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
